bounceback_filter: RTL and testbench

BOUNCEBACK_FILTER -- requirements
Module: bounceback_filter

---
 rtl/bounceback_filter.sv | 168 ++++++++++++++++
 tb/tb_bounceback_filter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bounceback_filter.sv
// -----------------------------------------------------------------------------
// bounceback_filter
//
// Debounces the bounceback sensor line before it reaches the edge-capture PIO.
// raw_in is synchronised through two flops. A change on the synchronised level
// is accepted only after thresh+1 consecutive samples disagree with the current
// filtered level. Shorter excursions are dropped and counted as glitches.
// Accepted rising edges are counted. A small Avalon-MM slave gives software
// access to the threshold and the counters.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-high reset
//   raw_in       : unsynchronised sensor input
//   address      : Avalon register select (0 status, 1 thresh, 2 edges, 3 glitches)
//   chipselect   : Avalon slave select
//   write_n      : Avalon active-low write strobe
//   writedata    : Avalon write data
//   readdata     : Avalon read data, registered one clock after address
//   filtered_out : debounced level driving the edge-capture PIO in_port
//
// Bus handshake: the slave has no wait states. A write takes effect on the
// clock edge where chipselect is high and write_n is low. readdata always
// reflects the register selected by address on the previous clock edge,
// whether or not chipselect is asserted.
// -----------------------------------------------------------------------------
module bounceback_filter #(
   parameter logic [15:0] DEF_THRESH = 16'd100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        raw_in,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        filtered_out
);

   typedef enum logic {
      STABLE  = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        s1;
   logic        sync_in;
   logic [15:0] cnt;
   logic [15:0] cnt_nxt;
   logic        filt_nxt;
   logic        glitch;
   logic        rise;
   logic [15:0] thresh;
   logic [15:0] edge_cnt;
   logic [7:0]  glitch_cnt;
   logic        wr;
   logic [15:0] rd_mux;

   assign wr = chipselect & ~write_n;

   // Two-flop synchroniser; nothing else looks at raw_in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1      <= 1'b0;
         sync_in <= 1'b0;
      end else begin
         s1      <= raw_in;
         sync_in <= s1;
      end
   end

   // Debounce FSM: state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= STABLE;
         cnt          <= 16'd0;
         filtered_out <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         filtered_out <= filt_nxt;
      end
   end

   // Debounce FSM: next state. cnt holds the number of mismatching samples
   // seen so far in PENDING. Comparing it against the live thresh means a
   // threshold lowered below cnt completes the transition on the next
   // mismatching sample.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      filt_nxt  = filtered_out;
      glitch    = 1'b0;
      case (state)
         STABLE: begin
            if (sync_in != filtered_out) begin
               if (thresh == 16'd0) begin
                  filt_nxt = sync_in;
               end else begin
                  state_nxt = PENDING;
                  cnt_nxt   = 16'd1;
               end
            end
         end
         PENDING: begin
            if (sync_in == filtered_out) begin
               glitch    = 1'b1;
               state_nxt = STABLE;
            end else if (cnt >= thresh) begin
               filt_nxt  = sync_in;
               state_nxt = STABLE;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         default: state_nxt = STABLE;
      endcase
   end

   assign rise = filt_nxt & ~filtered_out;

   // Software registers. A clear in the same cycle as an increment wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         thresh     <= DEF_THRESH;
         edge_cnt   <= 16'd0;
         glitch_cnt <= 8'd0;
      end else begin
         if (wr && (address == 2'd1)) begin
            thresh <= writedata;
         end

         if (wr && (address == 2'd2)) begin
            edge_cnt <= 16'd0;
         end else if (rise && (edge_cnt != 16'hFFFF)) begin
            edge_cnt <= edge_cnt + 16'd1;
         end

         if (wr && (address == 2'd3)) begin
            glitch_cnt <= 8'd0;
         end else if (glitch && (glitch_cnt != 8'hFF)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
         end
      end
   end

   always_comb begin
      rd_mux = 16'd0;
      case (address)
         2'd0:    rd_mux = {14'd0, sync_in, filtered_out};
         2'd1:    rd_mux = thresh;
         2'd2:    rd_mux = edge_cnt;
         2'd3:    rd_mux = {8'd0, glitch_cnt};
         default: rd_mux = 16'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= 16'd0;
      end else begin
         readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_bounceback_filter.sv
// -----------------------------------------------------------------------------
// tb_bounceback_filter
//
// Directed bench for bounceback_filter. A reference model follows the
// debounce rules as run lengths of mismatching samples. A compare process
// checks filtered_out and readdata against that model on every falling edge.
// Directed scenarios add hand-computed literal expectations for latency and
// register readback.
// -----------------------------------------------------------------------------
module tb_bounceback_filter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        raw_in = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [15:0] writedata = 16'd0;
   logic [15:0] readdata;
   logic        filtered_out;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   bounceback_filter #(.DEF_THRESH(16'd100)) dut (
      .clk          (clk),
      .reset        (reset),
      .raw_in       (raw_in),
      .address      (address),
      .chipselect   (chipselect),
      .write_n      (write_n),
      .writedata    (writedata),
      .readdata     (readdata),
      .filtered_out (filtered_out)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   // Sensor path: the level seen by the filter is raw_in two clocks late.
   // Debounce: a run of consecutive samples that differ from the filtered
   // level flips the level once the run reaches thresh+1 samples. A run that
   // ends early is a glitch.
   logic        m_s1, m_sync, m_filt;
   int          m_run;
   logic [15:0] m_thresh;
   int          m_edge, m_glitch;
   logic [15:0] m_rd;
   bit          m_rise, m_glt;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_s1 = 0; m_sync = 0; m_filt = 0; m_run = 0;
         m_thresh = 16'd100; m_edge = 0; m_glitch = 0; m_rd = 16'd0;
      end else begin
         case (address)
            2'd0: m_rd = {14'd0, m_sync, m_filt};
            2'd1: m_rd = m_thresh;
            2'd2: m_rd = m_edge[15:0];
            default: m_rd = {8'd0, m_glitch[7:0]};
         endcase
         m_rise = 0;
         m_glt  = 0;
         if (m_sync != m_filt) begin
            m_run = m_run + 1;
            if (m_run >= int'(m_thresh) + 1) begin
               m_filt = m_sync;
               m_run  = 0;
               m_rise = m_filt;
            end
         end else begin
            if (m_run > 0) m_glt = 1;
            m_run = 0;
         end
         if (m_rise && m_edge < 65535) m_edge = m_edge + 1;
         if (m_glt && m_glitch < 255) m_glitch = m_glitch + 1;
         if (chipselect && !write_n) begin
            if (address == 2'd1) m_thresh = writedata;
            if (address == 2'd2) m_edge = 0;
            if (address == 2'd3) m_glitch = 0;
         end
         m_sync = m_s1;
         m_s1   = raw_in;
      end
   end

   // ---------------- scoreboard: per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (filtered_out !== m_filt) begin
            failures++;
            $display("FAIL cyc_filtered_out t=%0t got=%0b exp=%0b", $time, filtered_out, m_filt);
         end
         checks++;
         if (readdata !== m_rd) begin
            failures++;
            $display("FAIL cyc_readdata t=%0t got=%h exp=%h", $time, readdata, m_rd);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
      address = a;
      tick();
      d = readdata;
   endtask

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Counts clocks until filtered_out reaches v; returns max if it never does.
   task automatic wait_filt(input logic v, input int max, output int n);
      n = max;
      for (int i = 1; i <= max; i++) begin
         tick();
         if (filtered_out == v) begin
            n = i;
            break;
         end
      end
   endtask

   // ---------------- directed stimulus ----------------
   logic [15:0] rd;
   int          n;
   logic        raw_seq [0:19];

   initial begin
      #1;
      reset  = 1'b1;
      chk_en = 1'b1;
      address = 2'd1;
      ticks(2);
      check("reset_filtered", {15'd0, filtered_out}, 16'd0);
      check("reset_readdata", readdata, 16'd0);
      reset = 1'b0;
      bus_rd(2'd1, rd); check("reset_thresh", rd, 16'd100);
      bus_rd(2'd2, rd); check("reset_edge", rd, 16'd0);

      // thresh=4, held rise: 7 clocks from raw edge
      bus_wr(2'd1, 16'd4);
      raw_in = 1'b1;
      wait_filt(1'b1, 30, n);
      check("t4_latency", n[15:0], 16'd7);
      bus_rd(2'd2, rd); check("t4_edge", rd, 16'd1);
      raw_in = 1'b0;
      ticks(10);

      // thresh=4, 3-clock pulse: glitch
      bus_wr(2'd3, 16'd0);
      bus_wr(2'd2, 16'd0);
      raw_in = 1'b1;
      ticks(3);
      raw_in = 1'b0;
      ticks(12);
      check("glitch_filtered", {15'd0, filtered_out}, 16'd0);
      bus_rd(2'd3, rd); check("glitch_cnt", rd, 16'd1);
      bus_rd(2'd2, rd); check("glitch_edge", rd, 16'd0);

      // thresh=0, toggle every 2 clocks: follows with 3-clock latency
      bus_wr(2'd1, 16'd0);
      bus_wr(2'd2, 16'd0);
      for (int t = 0; t < 20; t++) raw_seq[t] = (t < 16) ? ((t >> 1) & 1) : 1'b0;
      for (int t = 0; t < 20; t++) begin
         raw_in = raw_seq[t];
         tick();
         check($sformatf("t0_follow_%0d", t), {15'd0, filtered_out},
               {15'd0, (t >= 2) ? raw_seq[t-2] : 1'b0});
      end
      bus_rd(2'd2, rd); check("t0_edge", rd, 16'd4);

      // edge_cnt saturation
      force dut.edge_cnt = 16'hFFFF;
      m_edge = 65535;
      tick();
      release dut.edge_cnt;
      raw_in = 1'b1;
      ticks(4);
      bus_rd(2'd2, rd); check("edge_sat", rd, 16'hFFFF);
      raw_in = 1'b0;
      ticks(4);

      // clear on the same edge as a rise
      raw_in = 1'b1;
      ticks(2);
      bus_wr(2'd2, 16'd0);
      check("clr_rise_filtered", {15'd0, filtered_out}, 16'd1);
      bus_rd(2'd2, rd); check("clr_wins", rd, 16'd0);
      raw_in = 1'b0;
      ticks(4);

      // thresh lowered mid-PENDING
      bus_wr(2'd1, 16'd100);
      raw_in = 1'b1;
      ticks(52);
      check("mid_before", {15'd0, filtered_out}, 16'd0);
      bus_wr(2'd1, 16'd2);
      check("mid_at_write", {15'd0, filtered_out}, 16'd0);
      tick();
      check("mid_next_sample", {15'd0, filtered_out}, 16'd1);
      bus_rd(2'd1, rd); check("mid_thresh_rb", rd, 16'd2);
      raw_in = 1'b0;
      ticks(8);

      // reset mid-PENDING, release with raw_in held high
      bus_wr(2'd1, 16'd100);
      raw_in = 1'b1;
      ticks(5);
      reset = 1'b1;
      ticks(3);
      check("rst_pend_filtered", {15'd0, filtered_out}, 16'd0);
      check("rst_pend_readdata", readdata, 16'd0);
      reset = 1'b0;
      wait_filt(1'b1, 200, n);
      check("rst_release_latency", n[15:0], 16'd103);
      bus_rd(2'd3, rd); check("rst_glitch", rd, 16'd0);
      bus_rd(2'd2, rd); check("rst_edge", rd, 16'd1);
      bus_rd(2'd0, rd); check("rst_status", rd, 16'd3);
      ticks(2);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
